// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator stage and its
// companion handshake blocks.
package product_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_LEN_W  = 4;

endpackage : product_acc_pkg

// File: rtl/product_accumulator_if.sv
// Control/data bundle between the multiplier side and the product accumulator.
// The master drives commands and products; the slave returns the sum and status.
interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
);

    logic              clear;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic [PROD_W-1:0] mul_result;
    logic              mul_done;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              busy;
    logic              overflow;

    modport master (
        output clear, start, vec_len, mul_result, mul_done,
        input  acc_out, acc_valid, busy, overflow
    );

    modport slave (
        input  clear, start, vec_len, mul_result, mul_done,
        output acc_out, acc_valid, busy, overflow
    );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_rise_detect.sv
// Rising-edge detector for level-type handshake flags: one rise_o pulse per
// 0->1 transition of level_i.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule : rise_detect

// File: rtl/product_accumulator.sv
// Sums vec_len multiplier products (one per rise of mul_done) into an ACC_W-bit
// value. Define PRODUCT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    product_accumulator_if.slave bus
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W:0]   sum;
    logic             beat;

    rise_detect u_rise_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (bus.mul_done),
        .rise_o  (beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.mul_result};

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        cnt_d = '0;
                        if (bus.vec_len != '0) begin
                            len_d   = bus.vec_len;
                            state_d = ACCUM;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
`ifdef PRODUCT_ACC_SAT_EN
                        if (sum[ACC_W] || ovf_q) acc_d = '1;
                        else                     acc_d = sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        if (sum[ACC_W]) ovf_d = 1'b1;
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q == ACCUM);
    // A clear landing on the DONE cycle withdraws the result pulse.
    assign bus.acc_valid = (state_q == DONE) && !bus.clear;

endmodule : product_accumulator
